// File: rtl/ad_ip_jesd204_tpl_pkg.sv
// rtl/ad_ip_jesd204_tpl_pkg.sv - shared JESD204 TPL derived widths and sync FSM states
package ad_ip_jesd204_tpl_pkg;

    typedef enum logic {
        SYNC_IDLE  = 1'b0,
        SYNC_ARMED = 1'b1
    } sync_state_e;

    // Octets per frame: F = M*NP*S/(8*L)
    function automatic int calc_f(input int l, input int m, input int np, input int s);
        return (m * np * s) / (8 * l);
    endfunction

    function automatic int calc_frames_per_beat(input int octets_per_beat, input int f);
        return octets_per_beat / f;
    endfunction

    function automatic int calc_data_path_width(input int frames_per_beat, input int s);
        return frames_per_beat * s;
    endfunction

    function automatic int calc_link_data_width(input int l, input int octets_per_beat);
        return 8 * l * octets_per_beat;
    endfunction

endpackage

// File: rtl/ad_ip_jesd204_tpl_adc_fmt.sv
// rtl/ad_ip_jesd204_tpl_adc_fmt.sv - per-sample formatter: MSB extract, MSB invert, sign/zero extend
//   word        : NP-bit deframed word, converter bits MSB-aligned
//   dfmt_enable : 1 = sign-extend, 0 = zero-extend
//   dfmt_type   : 1 = invert converter MSB
//   sample      : DMA_BITS_PER_SAMPLE-bit formatted sample
module ad_ip_jesd204_tpl_adc_fmt #(
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int DMA_BITS_PER_SAMPLE  = 16
) (
    input  logic [BITS_PER_SAMPLE-1:0]     word,
    input  logic                           dfmt_enable,
    input  logic                           dfmt_type,
    output logic [DMA_BITS_PER_SAMPLE-1:0] sample
);

    logic [CONVERTER_RESOLUTION-1:0] conv;

    // Tail/control bits below the converter resolution are dropped here.
    logic unused_tail;
    assign unused_tail = ^word;

    always_comb begin
        conv = word[BITS_PER_SAMPLE-1 -: CONVERTER_RESOLUTION];
        conv[CONVERTER_RESOLUTION-1] = conv[CONVERTER_RESOLUTION-1] ^ dfmt_type;
        // Fill everything with the extension bit, then overlay the converter bits;
        // this also covers DMA width == resolution without a zero-width replication.
        sample = (dfmt_enable && conv[CONVERTER_RESOLUTION-1]) ? '1 : '0;
        sample[CONVERTER_RESOLUTION-1:0] = conv;
    end

endmodule

// File: rtl/ad_ip_jesd204_tpl_adc_deframer.sv
// rtl/ad_ip_jesd204_tpl_adc_deframer.sv - JESD204 RX transport layer deframer (optional TPL_ADC_EXT_SYNC_EN)
//   link_valid/link_data        : link-layer beats, lane l octet o at [(l*OPB+o)*8 +: 8]
//   enable, adc_dfmt_*          : regmap controls, sampled at stage 2
//   adc_sync_arm/in, _armed     : external sync arming (only with TPL_ADC_EXT_SYNC_EN)
//   adc_valid/adc_data          : per-channel samples, 2 clk after the beat
module ad_ip_jesd204_tpl_adc_deframer
    import ad_ip_jesd204_tpl_pkg::*;
#(
    parameter int NUM_LANES            = 4,
    parameter int NUM_CHANNELS         = 2,
    parameter int SAMPLES_PER_FRAME    = 1,
    parameter int CONVERTER_RESOLUTION = 16,
    parameter int BITS_PER_SAMPLE      = 16,
    parameter int DMA_BITS_PER_SAMPLE  = 16,
    parameter int OCTETS_PER_BEAT      = 4,
    localparam int F               = calc_f(NUM_LANES, NUM_CHANNELS, BITS_PER_SAMPLE, SAMPLES_PER_FRAME),
    localparam int FRAMES_PER_BEAT = calc_frames_per_beat(OCTETS_PER_BEAT, F),
    localparam int DATA_PATH_WIDTH = calc_data_path_width(FRAMES_PER_BEAT, SAMPLES_PER_FRAME),
    localparam int LINK_DATA_WIDTH = calc_link_data_width(NUM_LANES, OCTETS_PER_BEAT),
    localparam int NUM_WORDS       = NUM_CHANNELS * DATA_PATH_WIDTH
) (
    input  logic                                         clk,
    input  logic                                         resetn,
    input  logic                                         link_valid,
    input  logic [LINK_DATA_WIDTH-1:0]                   link_data,
    input  logic [NUM_CHANNELS-1:0]                      enable,
    input  logic                                         adc_dfmt_enable,
    input  logic                                         adc_dfmt_type,
    input  logic                                         adc_sync_arm,
    input  logic                                         adc_sync_in,
    output logic                                         adc_sync_armed,
    output logic [NUM_CHANNELS-1:0]                      adc_valid,
    output logic [NUM_WORDS*DMA_BITS_PER_SAMPLE-1:0]     adc_data
);

    localparam int FRAME_W = 8 * NUM_LANES * F;
    localparam int NP      = BITS_PER_SAMPLE;
    localparam int DW      = DMA_BITS_PER_SAMPLE;

    logic [FRAME_W-1:0]          frame_c;
    logic [NUM_WORDS*NP-1:0]     word_d, word_q;
    logic [NUM_WORDS*DW-1:0]     fmt_c;
    logic                        valid1_d, valid1_q;
    logic                        gate1_d, gate1_q;
    logic                        gate_c;
    logic [NUM_WORDS*DW-1:0]     data_d, data_q;
    logic [NUM_CHANNELS-1:0]     valid_d, valid_q;

    // Deframe: words are stored in output order, word (m, i) at (m*DPW + i)*NP.
    always_comb begin
        frame_c = '0;
        word_d  = '0;
        for (int j = 0; j < FRAMES_PER_BEAT; j++) begin
            // Lane 0 and its earliest octet form the most significant end of the frame.
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int q = 0; q < F; q++) begin
                    frame_c[FRAME_W - 8*(l*F + q + 1) +: 8] =
                        link_data[(l*OCTETS_PER_BEAT + j*F + q)*8 +: 8];
                end
            end
            for (int m = 0; m < NUM_CHANNELS; m++) begin
                for (int s = 0; s < SAMPLES_PER_FRAME; s++) begin
                    word_d[(m*DATA_PATH_WIDTH + j*SAMPLES_PER_FRAME + s)*NP +: NP] =
                        frame_c[FRAME_W - NP*(m*SAMPLES_PER_FRAME + s + 1) +: NP];
                end
            end
        end
    end

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_fmt
        ad_ip_jesd204_tpl_adc_fmt #(
            .CONVERTER_RESOLUTION (CONVERTER_RESOLUTION),
            .BITS_PER_SAMPLE      (BITS_PER_SAMPLE),
            .DMA_BITS_PER_SAMPLE  (DMA_BITS_PER_SAMPLE)
        ) u_fmt (
            .word        (word_q[w*NP +: NP]),
            .dfmt_enable (adc_dfmt_enable),
            .dfmt_type   (adc_dfmt_type),
            .sample      (fmt_c[w*DW +: DW])
        );
    end

`ifdef TPL_ADC_EXT_SYNC_EN
    sync_state_e state_d, state_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            SYNC_IDLE:  if (adc_sync_arm) state_d = SYNC_ARMED;
            SYNC_ARMED: if (link_valid && adc_sync_in) state_d = SYNC_IDLE;
            default:    state_d = SYNC_IDLE;
        endcase
        // The beat that carries the sync event is already let through.
        gate_c = (state_q == SYNC_ARMED) && !(link_valid && adc_sync_in);
    end

    assign adc_sync_armed = (state_q == SYNC_ARMED);
`else
    logic unused_sync;
    assign unused_sync    = adc_sync_arm ^ adc_sync_in;
    assign gate_c         = 1'b0;
    assign adc_sync_armed = 1'b0;
`endif

    always_comb begin
        valid1_d = link_valid;
        gate1_d  = gate_c;
        data_d   = valid1_q ? fmt_c : data_q;
        valid_d  = (valid1_q && !gate1_q) ? enable : '0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            word_q   <= '0;
            valid1_q <= 1'b0;
            gate1_q  <= 1'b0;
            data_q   <= '0;
            valid_q  <= '0;
`ifdef TPL_ADC_EXT_SYNC_EN
            state_q  <= SYNC_IDLE;
`endif
        end else begin
            word_q   <= word_d;
            valid1_q <= valid1_d;
            gate1_q  <= gate1_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
`ifdef TPL_ADC_EXT_SYNC_EN
            state_q  <= state_d;
`endif
        end
    end

    assign adc_valid = valid_q;
    assign adc_data  = data_q;

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv
// tb/tb_ad_ip_jesd204_tpl_adc_deframer.sv - bench for the TPL ADC deframer (N=16 and N=12 instances)
module tb_ad_ip_jesd204_tpl_adc_deframer;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         link_valid;
    logic [127:0] link_data;
    logic [1:0]   enable;
    logic         dfmt_en;
    logic         dfmt_ty;
    logic         arm;
    logic         sync_in;

    logic         armed, armed12;
    logic [1:0]   adc_valid, adc_valid12;
    logic [127:0] adc_data, adc_data12;

    int vec = 0;
    int miscmp = 0;

    // Reference model state: previous beat, expected outputs, armed flag.
    bit           m_armed;
    bit           p_valid;
    bit           p_gate;
    logic [127:0] p_data;
    logic [1:0]   e_valid;
    logic [127:0] e_d16, e_d12;

    ad_ip_jesd204_tpl_adc_deframer dut (
        .clk(clk), .resetn(resetn), .link_valid(link_valid), .link_data(link_data),
        .enable(enable), .adc_dfmt_enable(dfmt_en), .adc_dfmt_type(dfmt_ty),
        .adc_sync_arm(arm), .adc_sync_in(sync_in), .adc_sync_armed(armed),
        .adc_valid(adc_valid), .adc_data(adc_data)
    );

    ad_ip_jesd204_tpl_adc_deframer #(.CONVERTER_RESOLUTION(12)) dut12 (
        .clk(clk), .resetn(resetn), .link_valid(link_valid), .link_data(link_data),
        .enable(enable), .adc_dfmt_enable(dfmt_en), .adc_dfmt_type(dfmt_ty),
        .adc_sync_arm(arm), .adc_sync_in(sync_in), .adc_sync_armed(armed12),
        .adc_valid(adc_valid12), .adc_data(adc_data12)
    );

    // F=1: frame i is the i-th octet of lanes 0..3, lane 0 most significant;
    // channel 0 is the upper 16 bits of that frame, channel 1 the lower.
    function automatic logic [15:0] ref_sample(input logic [127:0] ld, input int m, input int i,
                                               input int n, input bit en, input bit ty);
        logic [31:0] frame;
        logic [15:0] word;
        int unsigned v;
        frame = {ld[(0*4+i)*8 +: 8], ld[(1*4+i)*8 +: 8], ld[(2*4+i)*8 +: 8], ld[(3*4+i)*8 +: 8]};
        word  = (m == 0) ? frame[31:16] : frame[15:0];
        v     = 32'(word) >> (16 - n);
        if (ty) v = v ^ (32'd1 << (n - 1));
        if (en && v[n-1]) v = v | ~((32'd1 << n) - 32'd1);
        return v[15:0];
    endfunction

    function automatic logic [127:0] lanes_const(input logic [7:0] a, input logic [7:0] b,
                                                 input logic [7:0] c, input logic [7:0] d);
        logic [127:0] r;
        for (int o = 0; o < 4; o++) begin
            r[(0*4+o)*8 +: 8] = a;
            r[(1*4+o)*8 +: 8] = b;
            r[(2*4+o)*8 +: 8] = c;
            r[(3*4+o)*8 +: 8] = d;
        end
        return r;
    endfunction

    task automatic check_outputs(input string tag);
        vec += 6;
        assert (adc_valid === e_valid) else begin
            miscmp++; $error("FAIL %s valid: got %b want %b", tag, adc_valid, e_valid);
        end
        assert (adc_valid12 === e_valid) else begin
            miscmp++; $error("FAIL %s valid12: got %b want %b", tag, adc_valid12, e_valid);
        end
        assert (adc_data === e_d16) else begin
            miscmp++; $error("FAIL %s data: got %h want %h", tag, adc_data, e_d16);
        end
        assert (adc_data12 === e_d12) else begin
            miscmp++; $error("FAIL %s data12: got %h want %h", tag, adc_data12, e_d12);
        end
        assert (armed === m_armed) else begin
            miscmp++; $error("FAIL %s armed: got %b want %b", tag, armed, m_armed);
        end
        assert (armed12 === m_armed) else begin
            miscmp++; $error("FAIL %s armed12: got %b want %b", tag, armed12, m_armed);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++; $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model with the inputs now applied, then compare after the edge.
    task automatic tick(input string tag);
        if (p_valid) begin
            e_valid = p_gate ? 2'b00 : enable;
            for (int m = 0; m < 2; m++)
                for (int i = 0; i < 4; i++) begin
                    e_d16[(m*4+i)*16 +: 16] = ref_sample(p_data, m, i, 16, dfmt_en, dfmt_ty);
                    e_d12[(m*4+i)*16 +: 16] = ref_sample(p_data, m, i, 12, dfmt_en, dfmt_ty);
                end
        end else begin
            e_valid = 2'b00;
        end
`ifdef TPL_ADC_EXT_SYNC_EN
        p_gate = m_armed && !(link_valid && sync_in);
        if (!m_armed && arm) m_armed = 1'b1;
        else if (m_armed && link_valid && sync_in) m_armed = 1'b0;
`else
        p_gate = 1'b0;
`endif
        p_valid = link_valid;
        p_data  = link_data;
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        #1;
        m_armed = 1'b0; p_valid = 1'b0; p_gate = 1'b0;
        e_valid = '0; e_d16 = '0; e_d12 = '0;
        check_outputs("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        resetn = 1'b1; link_valid = 1'b0; link_data = '0; enable = 2'b11;
        dfmt_en = 1'b0; dfmt_ty = 1'b0; arm = 1'b0; sync_in = 1'b0;
        p_data = '0;
        #2;
        do_reset();

        // Deframe
        link_data = lanes_const(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        link_valid = 1'b1; tick("deframe_beat");
        link_valid = 1'b0; tick("deframe_lat");
        vec++;
        assert (adc_valid === 2'b11) else begin
            miscmp++; $error("FAIL deframe_valid: got %b want 11", adc_valid);
        end
        for (int i = 0; i < 4; i++) begin
            chk16("deframe_ch0", adc_data[(0*4+i)*16 +: 16], 16'hA1B2);
            chk16("deframe_ch1", adc_data[(1*4+i)*16 +: 16], 16'hC3D4);
            chk16("n12_zext_ch0", adc_data12[(0*4+i)*16 +: 16], 16'h0A1B);
        end
        tick("deframe_after");
        vec++;
        assert (adc_valid === 2'b00) else begin
            miscmp++; $error("FAIL deframe_valid_drop: got %b want 00", adc_valid);
        end

        // Offset-binary conversion
        dfmt_ty = 1'b1;
        link_valid = 1'b1; tick("type_beat");
        link_valid = 1'b0; tick("type_lat");
        chk16("type_ch0", adc_data[0 +: 16], 16'h21B2);
        chk16("type_ch1", adc_data[4*16 +: 16], 16'h43D4);
        dfmt_ty = 1'b0;

        // Sign extension at N=12
        dfmt_en = 1'b1;
        link_valid = 1'b1; tick("sext_beat");
        link_valid = 1'b0; tick("sext_lat");
        chk16("n12_sext_ch0", adc_data12[0 +: 16], 16'hFA1B);
        dfmt_en = 1'b0;

        // Octet ordering
        link_data = '0;
        for (int o = 0; o < 4; o++) link_data[o*8 +: 8] = 8'(o);
        link_valid = 1'b1; tick("order_beat");
        link_valid = 1'b0; tick("order_lat");
        for (int i = 0; i < 4; i++)
            chk16("order_ch0", adc_data[i*16 +: 16], 16'(i) << 8);

        // Enable masking and gaps
        enable = 2'b01;
        link_data = {$urandom, $urandom, $urandom, $urandom};
        link_valid = 1'b1; tick("gap_b0");
        link_valid = 1'b0; tick("gap_b1");
        link_data = {$urandom, $urandom, $urandom, $urandom};
        link_valid = 1'b1; tick("gap_b2");
        link_valid = 1'b0; tick("gap_b3");
        tick("gap_b4");

        // External sync
        arm = 1'b1; tick("sync_arm");
        arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            link_data = {$urandom, $urandom, $urandom, $urandom};
            link_valid = 1'b1; tick("sync_gated");
        end
`ifdef TPL_ADC_EXT_SYNC_EN
        vec++;
        assert (armed === 1'b1) else begin
            miscmp++; $error("FAIL sync_armed: got %b want 1", armed);
        end
`endif
        sync_in = 1'b1; link_data = {$urandom, $urandom, $urandom, $urandom};
        tick("sync_beat6");
        sync_in = 1'b0; link_valid = 1'b0;
        tick("sync_lat");
        vec++;
        assert (adc_valid === 2'b01) else begin
            miscmp++; $error("FAIL sync_first_beat: got %b want 01", adc_valid);
        end
        tick("sync_after");

        // Arm and sync together while idle, then reset with pipeline full
        arm = 1'b1; sync_in = 1'b1; link_valid = 1'b1; tick("arm_sync_same");
        arm = 1'b0; sync_in = 1'b0;
`ifdef TPL_ADC_EXT_SYNC_EN
        vec++;
        assert (armed === 1'b1) else begin
            miscmp++; $error("FAIL arm_sync_same: got %b want 1", armed);
        end
`endif
        enable = 2'b11;
        arm = 1'b1; tick("arm_while_armed");
        arm = 1'b0; tick("fill");
        do_reset();
        link_valid = 1'b0;
        for (int k = 0; k < 3; k++) tick("post_reset");

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            link_valid = ($urandom_range(0, 3) != 0);
            link_data  = {$urandom, $urandom, $urandom, $urandom};
            enable     = 2'($urandom_range(0, 3));
            dfmt_en    = 1'($urandom_range(0, 1));
            dfmt_ty    = 1'($urandom_range(0, 1));
            arm        = ($urandom_range(0, 15) == 0);
            sync_in    = ($urandom_range(0, 3) == 0);
            tick("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end

endmodule
